// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding, config layout and helpers for accum_unit
package accum_pkg;
  localparam int CNT_W_DFLT = 16;
  typedef enum logic [1:0] {IDLE, DELAY, ACC, FINISH} state_t;
  typedef struct packed {
    logic [CNT_W_DFLT-1:0] delay;
    logic [CNT_W_DFLT-1:0] period;
    logic [CNT_W_DFLT-1:0] iterations;
  } cfg_t;
  function automatic logic [CNT_W_DFLT-1:0] eff_period_m1(input logic [CNT_W_DFLT-1:0] p);
    return p == '0 ? '0 : p - 1'b1;
  endfunction
endpackage

// File: rtl/accum_unit_if.sv
// accum_unit_if: operand stream, config fields and run/done handshake of accum_unit
interface accum_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W = accum_pkg::CNT_W_DFLT
);
  logic running, run, done;
  logic [DATA_W-1:0] in0, out0;
  logic [CNT_W-1:0] delay, period, iterations;
  modport master(output running, run, in0, delay, period, iterations, input done, out0);
  modport slave(input running, run, in0, delay, period, iterations, output done, out0);
endinterface

// File: rtl/accum_counter.sv
// accum_counter: loadable down-counter with enable and zero flag
module accum_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (en) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/accum_unit.sv
// accum_unit: delayed, periodic, repeated accumulator of in0 with run/done handshake
module accum_unit
  import accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = CNT_W_DFLT
) (
  input logic         clk,
  input logic         rst,
  accum_unit_if.slave bus
);
  state_t state;
  cfg_t cfg;
  logic [DATA_W-1:0] out0;
  logic [CNT_W-1:0] per_q, c0_val, c1_val;
  logic done, first, busy, accept;
  logic c0_load, c0_en, c0_zero, c1_load, c1_en, c1_zero;
  assign cfg = '{delay: bus.delay, period: bus.period, iterations: bus.iterations};
  assign busy = state == DELAY || state == ACC;
  assign accept = bus.running && bus.run && !busy;
  // c0 counts the delay, then the samples left in the current period; c1 counts periods left
  always_comb begin
    c0_load = accept || (bus.running && c0_zero && (state == DELAY || (state == ACC && !c1_zero)));
    c0_en = bus.running && busy && !c0_zero;
    c0_val = !accept ? per_q : cfg.delay != '0 ? cfg.delay - 1'b1 : eff_period_m1(cfg.period);
    c1_load = accept;
    c1_en = bus.running && state == ACC && c0_zero && !c1_zero;
    c1_val = cfg.iterations - 1'b1;
  end
  accum_counter #(.W(CNT_W)) u_cnt0 (
    .clk(clk), .rst(rst), .load(c0_load), .en(c0_en), .val(c0_val), .zero(c0_zero)
  );
  accum_counter #(.W(CNT_W)) u_cnt1 (
    .clk(clk), .rst(rst), .load(c1_load), .en(c1_en), .val(c1_val), .zero(c1_zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      done <= 1'b1;
      out0 <= '0;
      first <= 1'b0;
      per_q <= '0;
    end else if (bus.running) begin
      if (accept) begin
        per_q <= eff_period_m1(cfg.period);
        first <= 1'b1;
        done <= 1'b0;
        state <= cfg.iterations == '0 ? FINISH : cfg.delay == '0 ? ACC : DELAY;
      end else begin
        case (state)
          DELAY: if (c0_zero) state <= ACC;
          ACC: begin
            out0 <= first ? bus.in0 : out0 + bus.in0;
            first <= c0_zero;
            if (c0_zero && c1_zero) begin
              state <= FINISH;
              done <= 1'b1;
            end
          end
          FINISH: begin
            state <= IDLE;
            done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  assign bus.done = done;
  assign bus.out0 = out0;
endmodule
